sprite_line_renderer: RTL

Reader side of the sprite memory. It walks the sprite attribute slots once per scanline and fetches the 16-pixel row of every sprite visible on the upcoming line from sprite memory's read port. Fetched pixels are composited into a ping-pong pair of 256-entry line buffers. The video timing path reads the other buffer pixel by pixel, one line behind the fill.

---
 rtl/sprite_line_renderer_pkg.sv | 17 +
 rtl/sprite_line_renderer_line_buffer.sv | 38 +++
 rtl/sprite_line_renderer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_renderer_pkg.sv
// Shared sprite geometry constants and the fill-sequencer state type.
package sprite_line_renderer_pkg;

    localparam int unsigned SPR_DIM         = 16;
    localparam int unsigned SPR_PIX_W       = 4;
    localparam int unsigned SPR_MEM_AW      = 12;
    localparam int unsigned LINE_W          = 256;
    localparam logic [3:0]  SPR_TRANSPARENT = 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StEval,
        StFetch
    } state_e;

endpackage

// File: rtl/sprite_line_renderer_line_buffer.sv
// Ping-pong pair of 256x4 line RAMs: i_sel picks the fill RAM, the other one is displayed.
module sprite_line_renderer_line_buffer
    import sprite_line_renderer_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_sel,
    input  logic                 i_we,
    input  logic [7:0]           i_waddr,
    input  logic [SPR_PIX_W-1:0] i_wdata,
    input  logic                 i_rd,
    input  logic [7:0]           i_raddr,
    output logic [SPR_PIX_W-1:0] o_rdata
);

    logic [SPR_PIX_W-1:0] r_mem0 [LINE_W];
    logic [SPR_PIX_W-1:0] r_mem1 [LINE_W];
    logic [SPR_PIX_W-1:0] r_q0;
    logic [SPR_PIX_W-1:0] r_q1;
    logic                 r_rd_sel;

    always_ff @(posedge i_clk) begin
        if (i_we && !i_sel) r_mem0[i_waddr] <= i_wdata;
        if (i_rd)           r_q0 <= r_mem0[i_raddr];
    end

    always_ff @(posedge i_clk) begin
        if (i_we && i_sel) r_mem1[i_waddr] <= i_wdata;
        if (i_rd)          r_q1 <= r_mem1[i_raddr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rd) r_rd_sel <= i_sel;
    end

    // Display side is the RAM that is not being filled.
    assign o_rdata = r_rd_sel ? r_q0 : r_q1;

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite fetch and compositing into ping-pong line buffers.
// Optional horizontal flip is enabled by defining SPRITE_HFLIP_EN.
module sprite_line_renderer
    import sprite_line_renderer_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_line_start,
    input  logic [7:0]               i_line_y,
    input  logic [NUM_SPRITES-1:0]   i_spr_en,
    input  logic [8*NUM_SPRITES-1:0] i_spr_x,
    input  logic [8*NUM_SPRITES-1:0] i_spr_y,
    input  logic [4*NUM_SPRITES-1:0] i_spr_img,
`ifdef SPRITE_HFLIP_EN
    input  logic [NUM_SPRITES-1:0]   i_spr_hflip,
`endif
    output logic                     o_mem_ren,
    output logic [SPR_MEM_AW-1:0]    o_mem_raddr,
    input  logic [SPR_PIX_W-1:0]     i_mem_rdata,
    input  logic                     i_pix_rd,
    input  logic [7:0]               i_pix_x,
    output logic [SPR_PIX_W-1:0]     o_pix_color,
    output logic                     o_pix_opaque,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overrun
);

    logic [7:0]  w_x   [16];
    logic [7:0]  w_y   [16];
    logic [3:0]  w_img [16];
    logic [15:0] w_en;
    logic [15:0] w_flip;

    // Pad slot attributes out to 16 entries so a 4-bit slot index is always in range.
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
        if (gi < NUM_SPRITES) begin : g_used
            assign w_x[gi]   = i_spr_x[8*gi +: 8];
            assign w_y[gi]   = i_spr_y[8*gi +: 8];
            assign w_img[gi] = i_spr_img[4*gi +: 4];
            assign w_en[gi]  = i_spr_en[gi];
`ifdef SPRITE_HFLIP_EN
            assign w_flip[gi] = i_spr_hflip[gi];
`else
            assign w_flip[gi] = 1'b0;
`endif
        end else begin : g_unused
            assign w_x[gi]    = 8'd0;
            assign w_y[gi]    = 8'd0;
            assign w_img[gi]  = 4'd0;
            assign w_en[gi]   = 1'b0;
            assign w_flip[gi] = 1'b0;
        end
    end

    state_e     r_state, w_state_d;
    logic [3:0] r_slot, w_slot_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic [3:0] r_row, w_row_d;
    logic [7:0] r_line_y;
    logic       r_sel, r_done, r_overrun, r_disp_valid, r_pix_valid;
    logic       r_wb_valid;
    logic [8:0] r_wb_pos;
    logic       w_done_d;

    logic [7:0] w_cur_x, w_cur_y;
    logic [3:0] w_cur_img, w_col, w_mem_col;
    logic [8:0] w_diff;
    logic       w_visible;

    assign w_cur_x   = w_x[r_slot];
    assign w_cur_y   = w_y[r_slot];
    assign w_cur_img = w_img[r_slot];
    assign w_diff    = {1'b0, r_line_y} - {1'b0, w_cur_y};
    assign w_visible = w_en[r_slot] && (r_line_y >= w_cur_y) && (w_diff < 9'(SPR_DIM));
    assign w_col     = r_cnt[3:0];
    assign w_mem_col = w_flip[r_slot] ? ~w_col : w_col;

    assign o_busy = (r_state != StIdle);

    always_comb begin
        w_state_d = r_state;
        w_slot_d  = r_slot;
        w_cnt_d   = r_cnt;
        w_row_d   = r_row;
        w_done_d  = 1'b0;
        if (i_line_start) begin
            w_state_d = StClear;
            w_slot_d  = 4'(NUM_SPRITES - 1);
            w_cnt_d   = 8'd0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StClear: begin
                    w_cnt_d = r_cnt + 8'd1;
                    if (r_cnt == 8'd255) w_state_d = StEval;
                end
                StEval: begin
                    if (w_visible) begin
                        w_row_d   = w_diff[3:0];
                        w_cnt_d   = 8'd0;
                        w_state_d = StFetch;
                    end else if (r_slot == 4'd0) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else begin
                        w_slot_d = r_slot - 4'd1;
                    end
                end
                StFetch: begin
                    w_cnt_d = r_cnt + 8'd1;
                    if (w_col == 4'd15) begin
                        w_cnt_d = 8'd0;
                        if (r_slot == 4'd0) begin
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                        end else begin
                            w_slot_d  = r_slot - 4'd1;
                            w_state_d = StEval;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_slot       <= 4'd0;
            r_cnt        <= 8'd0;
            r_row        <= 4'd0;
            r_line_y     <= 8'd0;
            r_sel        <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_pos     <= 9'd0;
        end else begin
            r_state    <= w_state_d;
            r_slot     <= w_slot_d;
            r_cnt      <= w_cnt_d;
            r_row      <= w_row_d;
            r_done     <= w_done_d;
            r_overrun  <= i_line_start && o_busy;
            r_wb_valid <= (r_state == StFetch) && !i_line_start;
            r_wb_pos   <= {1'b0, w_cur_x} + {5'd0, w_col};
            if (i_line_start) begin
                r_sel    <= ~r_sel;
                r_line_y <= i_line_y;
            end
            if (w_done_d) r_disp_valid <= 1'b1;
            if (i_pix_rd) r_pix_valid <= r_disp_valid;
        end
    end

    assign o_done      = r_done;
    assign o_overrun   = r_overrun;
    assign o_mem_ren   = (r_state == StFetch);
    assign o_mem_raddr = (r_state == StFetch) ? {w_cur_img, r_row, w_mem_col} : 12'd0;

    logic                 w_kill, w_buf_we;
    logic [7:0]           w_buf_waddr;
    logic [SPR_PIX_W-1:0] w_buf_wdata, w_rd_data;

    // An abort drops whatever write would land on the swap edge.
    assign w_kill      = i_line_start && o_busy;
    assign w_buf_we    = !w_kill && ((r_state == StClear) ||
                         (r_wb_valid && (i_mem_rdata != SPR_TRANSPARENT) && !r_wb_pos[8]));
    assign w_buf_waddr = (r_state == StClear) ? r_cnt : r_wb_pos[7:0];
    assign w_buf_wdata = (r_state == StClear) ? SPR_TRANSPARENT : i_mem_rdata;

    sprite_line_renderer_line_buffer u_line_buffer (
        .i_clk   (i_clk),
        .i_sel   (r_sel),
        .i_we    (w_buf_we),
        .i_waddr (w_buf_waddr),
        .i_wdata (w_buf_wdata),
        .i_rd    (i_pix_rd),
        .i_raddr (i_pix_x),
        .o_rdata (w_rd_data)
    );

    assign o_pix_color  = r_pix_valid ? w_rd_data : SPR_TRANSPARENT;
    assign o_pix_opaque = r_pix_valid && (w_rd_data != SPR_TRANSPARENT);

endmodule
